// File: rtl/npu_cube_para_booth_encoder.sv
// Radix-4 Booth encoder for the cube weight path: two-stage valid/ready
// pipe; raw weights in, packed select codes + unsigned-overflow mask out.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready/in_para   raw weight beat (lane k = DWB bits at DWB*k)
//   is_signed                   1 = two's complement, sampled with the beat
//   out_valid/out_ready         code beat handshake
//   out_para_code               packed codes (lane k = DWB_CODE bits)
//   out_is_signed               is_signed travelling with the beat
//   out_ovf_mask                per-lane "unsigned weight not representable"
//   ovf_sticky, beat_cnt        statistics, cleared by stat_clr
module npu_cube_para_booth_encoder #(
  parameter int DWB              = 8,
  parameter int NPU_CUBE_MAC_NUM = 8,
  parameter int DWB_CODE         = 3 * (DWB / 2),
  parameter int CNTW             = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DWB*NPU_CUBE_MAC_NUM-1:0]      in_para,
  input  logic                               is_signed,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DWB_CODE*NPU_CUBE_MAC_NUM-1:0] out_para_code,
  output logic                               out_is_signed,
  output logic [NPU_CUBE_MAC_NUM-1:0]          out_ovf_mask,
  output logic                               ovf_sticky,
  input  logic                               stat_clr,
  output logic [CNTW-1:0]                    beat_cnt
);

  localparam int NDIG = DWB / 2;
  localparam int NL   = NPU_CUBE_MAC_NUM;
  localparam int PW   = DWB * NL;
  localparam int CW   = DWB_CODE * NL;

  logic          r_s1_valid;
  logic [PW-1:0] r_s1_para;
  logic          r_s1_sgn;

  logic          r_s2_valid;
  logic [CW-1:0] r_s2_code;
  logic [NL-1:0] r_s2_mask;
  logic          r_s2_sgn;

  logic            r_sticky;
  logic [CNTW-1:0] r_cnt;

  logic          w_s2_load;
  logic          w_xfer;
  logic [CW-1:0] w_code;
  logic [NL-1:0] w_mask;
  logic [DWB:0]  w_ext [NL];

  // Zero digits (both 000 and 111 triples) map to the canonical 3'b000.
  function automatic logic [2:0] booth_dig(input logic [2:0] t);
    logic [2:0] c;
    c = 3'b000;
    unique case (t)
      3'b000:  c = 3'b000;
      3'b001:  c = 3'b001;
      3'b010:  c = 3'b001;
      3'b011:  c = 3'b010;
      3'b100:  c = 3'b110;
      3'b101:  c = 3'b101;
      3'b110:  c = 3'b101;
      3'b111:  c = 3'b000;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  assign w_s2_load = !r_s2_valid | out_ready;
  assign in_ready  = !r_s1_valid | w_s2_load;
  assign w_xfer    = r_s2_valid & out_ready;

  // Append the implicit w[-1] = 0 below each lane.
  for (genvar k = 0; k < NL; k++) begin : g_ext
    assign w_ext[k] = {r_s1_para[k*DWB +: DWB], 1'b0};
  end

  always_comb begin
    w_code = '0;
    w_mask = '0;
    for (int k = 0; k < NL; k++) begin
      for (int i = 0; i < NDIG; i++) begin
        w_code[k*DWB_CODE + 3*i +: 3] =
          booth_dig(w_ext[k][2*i +: 3]);
      end
      // Unsigned weight with MSB set encodes as w - 2^DWB.
      w_mask[k] = !r_s1_sgn & r_s1_para[k*DWB + DWB - 1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_para  <= '0;
      r_s1_sgn   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_para <= in_para;
        r_s1_sgn  <= is_signed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_code  <= '0;
      r_s2_mask  <= '0;
      r_s2_sgn   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_code <= w_code;
        r_s2_mask <= w_mask;
        r_s2_sgn  <= r_s1_sgn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (stat_clr) begin
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (w_xfer) begin
      r_cnt    <= r_cnt + CNTW'(1);
      r_sticky <= r_sticky | (|r_s2_mask);
    end
  end

  assign out_valid     = r_s2_valid;
  assign out_para_code = r_s2_code;
  assign out_ovf_mask  = r_s2_mask;
  assign out_is_signed = r_s2_sgn;
  assign ovf_sticky    = r_sticky;
  assign beat_cnt      = r_cnt;

endmodule

// File: tb/tb_npu_cube_para_booth_encoder.sv
// Bench for npu_cube_para_booth_encoder: directed beats plus random
// traffic against an arithmetic Booth-digit model and a beat queue.
module tb_npu_cube_para_booth_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_para;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_para_code;
  logic        out_is_signed;
  logic [7:0]  out_ovf_mask;
  logic        ovf_sticky;
  logic        stat_clr;
  logic [15:0] beat_cnt;

  npu_cube_para_booth_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_para       (in_para),
    .is_signed     (is_signed),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_para_code (out_para_code),
    .out_is_signed (out_is_signed),
    .out_ovf_mask  (out_ovf_mask),
    .ovf_sticky    (ovf_sticky),
    .stat_clr      (stat_clr),
    .beat_cnt      (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] code;
    logic [7:0]  mask;
    logic        sgn;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_cnt;
  logic        m_sticky;
  int          n_chk;
  int          n_fail;

  logic        d_iv;
  logic [63:0] d_para;
  logic        d_sgn;
  logic        d_ordy;
  logic        d_clr;
  logic        last_acc;
  logic        last_xfer;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Digit i = w[2i-1] + w[2i] - 2*w[2i+1]; code = {sign, |digit|}.
  function automatic exp_t model(input logic [63:0] p, input logic s);
    exp_t       e;
    logic [8:0] ext;
    int         d;
    logic [2:0] c;
    e.code = '0;
    e.mask = '0;
    e.sgn  = s;
    for (int k = 0; k < 8; k++) begin
      ext = {p[8*k +: 8], 1'b0};
      for (int i = 0; i < 4; i++) begin
        d = int'(ext[2*i]) + int'(ext[2*i+1]) - 2 * int'(ext[2*i+2]);
        c[2]   = (d < 0);
        c[1:0] = 2'((d < 0) ? -d : d);
        e.code[12*k + 3*i +: 3] = c;
      end
      e.mask[k] = !s && ext[8];
    end
    return e;
  endfunction

  task automatic cyc();
    int c;
    @(negedge clk);
    in_valid  = d_iv;
    in_para   = d_para;
    is_signed = d_sgn;
    out_ready = d_ordy;
    stat_clr  = d_clr;
    #1;
    chk("beat_cnt", beat_cnt, m_cnt);
    chk("sticky", ovf_sticky, m_sticky);
    last_xfer = out_valid & out_ready;
    if (out_valid) begin
      chk("stale", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        chk("code", out_para_code, q[0].code);
        chk("mask", out_ovf_mask, q[0].mask);
        chk("osgn", out_is_signed, q[0].sgn);
      end
      c = 0;
      for (int j = 0; j < 32; j++)
        if (out_para_code[3*j +: 3] == 3'b100) c++;
      chk("neg0", c, 0);
    end
    last_acc = in_valid & in_ready;
    if (stat_clr) begin
      m_cnt    = '0;
      m_sticky = 1'b0;
    end else if (last_xfer && q.size() != 0) begin
      m_cnt    = m_cnt + 16'd1;
      m_sticky = m_sticky | (|q[0].mask);
    end
    if (last_xfer && q.size() != 0) void'(q.pop_front());
    if (last_acc) q.push_back(model(in_para, is_signed));
  endtask

  task automatic idle();
    d_iv  = 1'b0;
    d_clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    bit seen_nr;
    int sent;
    int guard;
    n_chk    = 0;
    n_fail   = 0;
    m_cnt    = '0;
    m_sticky = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0; in_para  = '0; is_signed = 1'b0;
    out_ready = 1'b0; stat_clr = 1'b0;
    d_iv = 0; d_para = '0; d_sgn = 0; d_ordy = 1; d_clr = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_code", out_para_code, 96'h0);
    chk("rst_mask", out_ovf_mask, 8'h0);
    chk("rst_osgn", out_is_signed, 1'b0);
    chk("rst_stky", ovf_sticky, 1'b0);
    chk("rst_cnt", beat_cnt, 16'h0);
    chk("rst_irdy", in_ready, 1'b1);
    rst_n = 1'b1;

    // all lanes 0x7F signed: +2,0,0,-1
    d_iv = 1; d_para = {8{8'h7F}}; d_sgn = 1; d_ordy = 1;
    cyc();
    chk("t1_acc", last_acc, 1'b1);
    idle();
    cyc();
    chk("lat_n1", out_valid, 1'b0);
    cyc();
    chk("lat_n2", out_valid, 1'b1);
    chk("t1_code", out_para_code, {8{12'h405}});
    chk("t1_mask", out_ovf_mask, 8'h00);
    cyc();

    // signed edge lanes 0x80, 0xFF, 0x01, 0x00
    d_iv = 1; d_sgn = 1;
    d_para = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h80};
    cyc();
    idle();
    repeat (2) cyc();
    chk("t2_ov", out_valid, 1'b1);
    chk("t2_code", out_para_code,
        {48'h0, 12'h000, 12'h001, 12'h005, 12'hC00});
    cyc();

    // unsigned lane0 0xC8, others 0x10
    d_iv = 1; d_sgn = 0; d_para = {{7{8'h10}}, 8'hC8};
    cyc();
    idle();
    repeat (2) cyc();
    chk("t3_ov", out_valid, 1'b1);
    chk("t3_mask", out_ovf_mask, 8'h01);
    chk("t3_lanes", out_para_code[95:12], {7{12'h040}});
    chk("t3_lane0", out_para_code[11:0], 12'hA70);
    chk("t3_stk0", ovf_sticky, 1'b0);
    cyc();
    chk("t3_stk1", ovf_sticky, 1'b1);

    // 6-beat stream with out_ready low in cycles 3..5
    d_clr = 1; cyc(); d_clr = 0;
    sent = 0; seen_nr = 0;
    for (int t = 0; t < 20; t++) begin
      d_ordy = !(t >= 3 && t <= 5);
      d_iv   = (sent < 6);
      d_para = {$urandom, $urandom};
      d_sgn  = 1'($urandom_range(0, 1));
      cyc();
      if (!in_ready) seen_nr = 1;
      if (last_acc) sent++;
    end
    d_ordy = 1;
    chk("bp_sent", sent, 6);
    chk("bp_irdy", seen_nr, 1'b1);
    chk("bp_cnt", beat_cnt, 16'd6);
    chk("bp_drain", q.size(), 0);

    // reset with two beats in flight
    d_iv = 1; d_para = {8{8'h3C}}; d_sgn = 1; d_ordy = 0;
    cyc();
    d_para = {8{8'hA5}};
    cyc();
    idle();
    cyc();
    chk("pre_rst_ov", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_cnt", beat_cnt, 16'h0);
    q.delete();
    m_cnt = '0; m_sticky = 1'b0;
    d_ordy = 1;
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      cyc();
      chk("post_rst_ov", out_valid, 1'b0);
    end
    chk("post_rst_cnt", beat_cnt, 16'h0);

    // random traffic with held source beats
    pend = 0;
    repeat (400) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend   = 1;
        d_para = {$urandom, $urandom};
        d_sgn  = 1'($urandom_range(0, 1));
      end
      d_iv   = pend;
      d_ordy = ($urandom_range(0, 3) != 0);
      d_clr  = ($urandom_range(0, 29) == 0);
      cyc();
      if (last_acc) pend = 0;
    end
    idle(); d_ordy = 1;
    repeat (4) cyc();
    chk("rnd_drain", q.size(), 0);

    // counter wrap at 16'hFFFF
    d_clr = 1; cyc(); d_clr = 0;
    d_iv = 1; d_sgn = 1; d_ordy = 1;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      d_para = {$urandom, $urandom};
      cyc();
      guard++;
    end
    chk("wrap_guard", guard < 70000, 1'b1);
    idle();
    cyc();
    chk("cnt_ffff", beat_cnt, 16'hFFFF);
    chk("wrap_xfer", last_xfer, 1'b1);
    cyc();
    chk("cnt_wrap", beat_cnt, 16'h0000);
    repeat (3) cyc();

    // stat_clr coinciding with a transfer
    d_iv = 1; d_sgn = 0; d_para = {8{8'hC8}};
    cyc();
    cyc();
    idle();
    cyc();
    chk("clr_a_ov", out_valid, 1'b1);
    d_clr = 1;
    cyc();
    chk("clr_stk_pre", ovf_sticky, 1'b1);
    chk("clr_xfer", last_xfer, 1'b1);
    d_clr = 0;
    cyc();
    chk("clr_cnt", beat_cnt, 16'h0);
    chk("clr_stk", ovf_sticky, 1'b0);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_cube_para_booth_encoder.md
Name: npu_cube_para_booth_encoder

Overview:
- Streaming radix-4 Booth encoder for the NPU cube weight path.
- Takes NPU_CUBE_MAC_NUM raw DWB-bit weights per beat and produces the packed partial-product select codes that the cube add-tree consumes on its para-code input.
- Two-stage valid/ready pipeline with full backpressure. Also reports unsigned weights that cannot be represented, and counts encoded beats.

Parameters:
- DWB, 8, raw weight width per lane; must be even.
- NPU_CUBE_MAC_NUM, 8, lanes per beat.
- NDIG, DWB/2, Booth digits per lane (derived; do not override).
- DWB_CODE, 3*NDIG (=12), code bits per lane.
- CNTW, 16, width of beat counter.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  weight beat valid
- in_ready  output  1  encoder can accept beat
- in_para  input  DWB*NPU_CUBE_MAC_NUM  raw weights; lane k = bits [DWB*k+DWB-1 : DWB*k]
- is_signed  input  1  sampled with beat: 1 = two's-complement weights, 0 = unsigned
- out_valid  output  1  code beat valid
- out_ready  input  1  downstream accepts code beat
- out_para_code  output  DWB_CODE*NPU_CUBE_MAC_NUM  packed codes; lane k = bits [DWB_CODE*k+DWB_CODE-1 : DWB_CODE*k]
- out_is_signed  output  1  is_signed travelling with the beat
- out_ovf_mask  output  NPU_CUBE_MAC_NUM  per-lane unrepresentable flag for this beat
- ovf_sticky  output  1  set by any accepted output beat with a nonzero mask
- stat_clr  input  1  synchronous clear of ovf_sticky and beat_cnt
- beat_cnt  output  CNTW  number of output beats transferred

Behaviour:
- Reset (rst_n=0, asynchronous): both stage valids=0, out_valid=0, out_para_code=0, out_ovf_mask=0, out_is_signed=0, ovf_sticky=0, beat_cnt=0. in_ready=1 after reset.
- Mid-operation reset discards all in-flight beats; no partial output.
- Stage 1 (S1) registers in_para and is_signed on in_valid & in_ready.
- Stage 2 (S2) registers encoded codes, mask and is_signed from S1. S2 drives the out_* ports directly from flops.
- Latency: input accept at cycle N -> out_valid at cycle N+2 when out_ready is held 1. Throughput: 1 beat/cycle.
- Backpressure:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !S1_valid | S2 loads (combinational from out_ready and stage valids).
  - A held output beat keeps its data stable until out_valid & out_ready.
- Encoding, per lane w[DWB-1:0], with w[-1]=0, for digit i = 0..NDIG-1 using triple {w[2i+1], w[2i], w[2i-1]}:
  - 000 -> 0
  - 001 -> +1
  - 010 -> +1
  - 011 -> +2
  - 100 -> -2
  - 101 -> -1
  - 110 -> -1
  - 111 -> 0
- Code for digit i occupies lane bits [3i+2:3i]:
  - bit2 = negate
  - bits[1:0] = magnitude: 00 = 0, 01 = 1x, 10 = 2x; 11 is never emitted.
- Zero digits are canonical: 3'b000. Negative zero (111 triple) must not emit 3'b100.
- Represented value = sum over i of digit_i * 4^i.
- is_signed=1: exact for all two's-complement weights; mask bit = 0.
- is_signed=0: the encoding is exact only when w[DWB-1]=0.
  - If w[DWB-1]=1, set the lane's mask bit.
  - The code is still emitted from the same table, so it represents w-2^DWB.
- Statistics, updated on each output transfer (out_valid & out_ready):
  - beat_cnt increments and wraps from 2^CNTW-1 to 0.
  - ovf_sticky |= |out_ovf_mask.
- stat_clr has priority over a same-cycle update: counter=0 and sticky=0 that cycle. The transferring beat is not counted.
- in_valid while in_ready=0: the beat is not taken; the source holds it.
- Simultaneous in-transfer and out-transfer with both stages full: the pipeline shifts with no bubble.

Test Plan:
- Signed, all lanes 8'h7F, out_ready=1 -> each lane code 12'h405 (digits +2,0,0,-1); mask 0; out_valid 2 cycles after accept.
- Signed lanes {0x80, 0xFF, 0x01, 0x00, ...} -> lane codes 12'hC00, 12'h005, 12'h001, 12'h000. No 3'b100 is ever present.
- Unsigned lane0 = 8'hC8, others 8'h10 -> out_ovf_mask = 8'h01; ovf_sticky rises the cycle after the transfer; other lanes encode exactly (0x10 -> 12'h040).
- Stream 6 beats with out_ready low for cycles 3-5 -> in_ready drops once S1 and S2 are full; no beat lost or duplicated; order preserved; beat_cnt = 6 at end.
- Assert rst_n low with 2 beats in flight -> out_valid=0 immediately; after release beat_cnt=0 and no stale beat emerges.
- beat_cnt at 16'hFFFF: a transfer wraps it to 0. stat_clr asserted in the same cycle as a transfer -> beat_cnt=0 and ovf_sticky=0.
